// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock-enable controller.
// Holds the active divisor, sequences start/stop from the level-sensitive
// `en`, and takes new divisors over a valid/ready handshake. A divisor that
// arrives while running is parked in pend_q and applied only at the next
// period boundary, so no period is ever cut short.
//
// Handshake: a transfer happens on any rising edge where cfg_valid and
// cfg_ready are both high; cfg_div is sampled only on that edge. cfg_ready
// is low only while a divisor is already waiting (PEND).
//
// Optional feature macro: CLK_DIV_CTRL_HALF_TICK_EN builds the mid-period
// half_tick pulse; without it half_tick is tied low.
module clk_div_ctrl #(
   parameter int unsigned IN_FREQ  = 50000000,
   parameter int unsigned OUT_FREQ = 9600,
   parameter int unsigned DIV_W    = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             tick,
   output logic             half_tick,
   output logic             new_clk,
   output logic             running
);

   // A divisor below 2 cannot produce a period, so 2 is the floor.
   localparam int unsigned      DEFAULT_RAW = IN_FREQ / OUT_FREQ;
   localparam logic [DIV_W-1:0] DEFAULT_DIV = (DEFAULT_RAW < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_RAW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] pend_q;
   logic [DIV_W-1:0] cfg_clamped;
   logic [DIV_W-1:0] cnt_inc;
   logic [DIV_W-1:0] half_div;
   logic             wrap;
   logic             xfer;

   assign cfg_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
   assign cnt_inc     = cnt + DIV_W'(1);
   assign half_div    = div_q >> 1;
   // div_q is never below 2, so div_q-1 cannot underflow.
   assign wrap        = (cnt == (div_q - DIV_W'(1)));
   assign cfg_ready   = (state != PEND);
   assign running     = (state != IDLE);
   assign xfer        = cfg_valid && cfg_ready;

   // Main sequencer: state, counter, divisor registers, tick and new_clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         div_q   <= DEFAULT_DIV;
         pend_q  <= '0;
         tick    <= 1'b0;
         new_clk <= 1'b0;
      end else begin
         tick    <= 1'b0;
         new_clk <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (xfer) begin
                  div_q <= cfg_clamped;
               end
               if (en) begin
                  state <= RUN;
               end
            end
            RUN, PEND: begin
               if (!en) begin
                  // Stop wins over a wrap; a waiting divisor is committed
                  // rather than dropped.
                  state <= IDLE;
                  cnt   <= '0;
                  if (state == PEND) begin
                     div_q <= pend_q;
                  end else if (xfer) begin
                     div_q <= cfg_clamped;
                  end
               end else begin
                  if ((state == RUN) && xfer) begin
                     pend_q <= cfg_clamped;
                     state  <= PEND;
                  end
                  if (wrap) begin
                     cnt  <= '0;
                     tick <= 1'b1;
                     if (state == PEND) begin
                        div_q <= pend_q;
                        state <= RUN;
                     end
                  end else begin
                     cnt     <= cnt_inc;
                     new_clk <= (cnt_inc >= half_div);
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef CLK_DIV_CTRL_HALF_TICK_EN
   // Mid-period pulse: fires as the counter steps onto div_q>>1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_tick <= 1'b0;
      end else if ((state != IDLE) && en && !wrap) begin
         half_tick <= (cnt_inc == half_div);
      end else begin
         half_tick <= 1'b0;
      end
   end
`else
   assign half_tick = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed test of clk_div_ctrl at default parameters.
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_clk_div_ctrl;

   localparam int DIV_W = 24;
`ifdef CLK_DIV_CTRL_HALF_TICK_EN
   localparam bit HALF = 1'b1;
`else
   localparam bit HALF = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             en;
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             tick;
   logic             half_tick;
   logic             new_clk;
   logic             running;

   int vectors;
   int miscompares;
   int n;

   clk_div_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .tick      (tick),
      .half_tick (half_tick),
      .new_clk   (new_clk),
      .running   (running)
   );

   // Clock: 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Count falling edges until tick is seen, bounded by limit.
   task automatic measure(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while ((tick !== 1'b1) && (cycles < limit));
   endtask

   // Divisor write while IDLE, one cycle long.
   task automatic write_idle(input logic [DIV_W-1:0] d);
      cfg_valid = 1'b1;
      cfg_div   = d;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Per-cycle check after RUN entry; k counts cycles since the entry edge.
   task automatic run_pattern(input int div, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         chk("pat_tick", tick, ((k % div) == 0) && (k > 0));
         chk("pat_new_clk", new_clk, (k % div) >= (div / 2));
         chk("pat_half_tick", half_tick, HALF && ((k % div) == (div / 2)));
         chk("pat_running", running, 1);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      en          = 1'b1;
      cfg_valid   = 1'b0;
      cfg_div     = 24'd3;

      // Reset held with activity on the inputs.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cfg_valid = ~cfg_valid;
         chk("rst_tick", tick, 0);
         chk("rst_new_clk", new_clk, 0);
         chk("rst_running", running, 0);
         chk("rst_cfg_ready", cfg_ready, 1);
         chk("rst_half_tick", half_tick, 0);
      end
      cfg_valid = 1'b0;
      rst       = 1'b1;

      // Default divisor 5208: first tick one edge later, then every 5208.
      measure(6000, n);
      chk("dflt_first", n, 5209);
      chk("dflt_running", running, 1);
      measure(6000, n);
      chk("dflt_period", n, 5208);

      en = 1'b0;
      @(negedge clk);
      chk("stop_running", running, 0);
      chk("stop_cfg_ready", cfg_ready, 1);
      chk("stop_tick", tick, 0);
      chk("stop_new_clk", new_clk, 0);

      // Basic run at divisor 4.
      chk("idle_cfg_ready", cfg_ready, 1);
      write_idle(24'd4);
      chk("idle_stays_idle", running, 0);
      en = 1'b1;
      run_pattern(4, 13);

      // Live update to 6 while cnt is 1.
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 24'd6;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("live_cfg_ready_low", cfg_ready, 0);
      measure(20, n);
      chk("live_old_period_end", n, 2);
      chk("live_cfg_ready_high", cfg_ready, 1);
      measure(20, n);
      chk("live_new_period_1", n, 6);
      measure(20, n);
      chk("live_new_period_2", n, 6);

      // Clamp: divisor 0 and 1 both behave as 2.
      en = 1'b0;
      @(negedge clk);
      write_idle(24'd0);
      en = 1'b1;
      run_pattern(2, 7);
      en = 1'b0;
      @(negedge clk);
      write_idle(24'd1);
      en = 1'b1;
      run_pattern(2, 7);

      // Stop in PEND mid-period (4 -> 7).
      en = 1'b0;
      @(negedge clk);
      write_idle(24'd4);
      en = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 24'd7;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("pend_cfg_ready", cfg_ready, 0);
      en = 1'b0;
      @(negedge clk);
      chk("pstop_running", running, 0);
      chk("pstop_tick", tick, 0);
      chk("pstop_new_clk", new_clk, 0);
      chk("pstop_half_tick", half_tick, 0);
      chk("pstop_cfg_ready", cfg_ready, 1);
      en = 1'b1;
      measure(20, n);
      chk("pstop_first", n, 8);
      measure(20, n);
      chk("pstop_period", n, 7);

      // Stop in PEND on the wrap edge (4 -> 7).
      en = 1'b0;
      @(negedge clk);
      write_idle(24'd4);
      en = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div   = 24'd7;
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("wstop_new_clk_k2", new_clk, 1);
      @(negedge clk);
      chk("wstop_new_clk_k3", new_clk, 1);
      chk("wstop_cfg_ready", cfg_ready, 0);
      en = 1'b0;
      @(negedge clk);
      chk("wstop_tick", tick, 0);
      chk("wstop_running", running, 0);
      chk("wstop_new_clk", new_clk, 0);
      chk("wstop_cfg_ready_hi", cfg_ready, 1);
      en = 1'b1;
      measure(20, n);
      chk("wstop_first", n, 8);
      measure(20, n);
      chk("wstop_period", n, 7);

      // Divisor 5: half_tick at cnt 2 when built, tick at cnt 0.
      en = 1'b0;
      @(negedge clk);
      write_idle(24'd5);
      en = 1'b1;
      run_pattern(5, 12);
      en = 1'b0;
      @(negedge clk);
      chk("end_running", running, 0);
      chk("end_half_tick", half_tick, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-enable controller for the UART/timer clock-divider path. It holds the active divisor, sequences start/stop, and accepts new divisors over a valid/ready handshake. New divisors are applied only at a period boundary, so the output never produces a runt period. It emits a one-cycle `tick` enable and a registered square `new_clk` for downstream logic clocked by `clk`.

## Interface
- `IN_FREQ`, 50000000, input clock frequency in Hz.
- `OUT_FREQ`, 9600, default output frequency in Hz; `DEFAULT_DIV = IN_FREQ/OUT_FREQ` (integer truncation, 5208 at defaults).
- `DIV_W`, 24, width of the divisor and counter; `DEFAULT_DIV` must fit.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: run request, level-sensitive.
- `cfg_valid` in 1: divisor write request.
- `cfg_div` in DIV_W: requested divisor in `clk` cycles.
- `cfg_ready` out 1: divisor write can be accepted.
- `tick` out 1: one-cycle pulse, once per period.
- `half_tick` out 1: one-cycle pulse at mid-period (see Configuration).
- `new_clk` out 1: registered divided clock, for use as data only.
- `running` out 1: high when not IDLE.

## Operation
- Registers: `state`, `cnt` (DIV_W), `div_q` (DIV_W), `pend_q` (DIV_W).
- States:
  - IDLE: `cnt` is held at 0.
  - RUN: `cnt` counts 0 to `div_q`-1, then wraps.
  - PEND: counting as in RUN, with a divisor waiting in `pend_q`.
- Divisor clamp: any accepted `cfg_div` < 2 is stored as 2. `DEFAULT_DIV` < 2 is also treated as 2.
- Handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`. `cfg_ready` = (state != PEND). `cfg_div` is sampled only on a transfer.
- IDLE + transfer: `div_q` ← clamped value; state stays IDLE.
- IDLE + `en`=1: go to RUN, `cnt` ← 0.
- RUN + transfer: `pend_q` ← clamped value; go to PEND.
- RUN/PEND, `cnt`==`div_q`-1: `cnt` ← 0 and `tick` is set. In PEND, additionally `div_q` ← `pend_q` and go to RUN.
- Otherwise in RUN/PEND: `cnt` ← `cnt`+1.
- `en`=0 in RUN/PEND: go to IDLE immediately.
  - `cnt` ← 0; `tick`, `half_tick` and `new_clk` ← 0.
  - In PEND, `pend_q` is committed to `div_q`; the pending divisor is never lost.
- `en`=0 on the same edge as a wrap: stop wins and no `tick` is emitted.
- `new_clk` ← (next `cnt` ≥ `div_q`>>1) while running, else 0. It is low for floor(div/2) cycles and high for ceil(div/2) cycles; its falling edge coincides with `tick`.
- Counter arithmetic is unsigned DIV_W. The wrap compare uses `div_q`-1, so there is no overflow because `div_q` ≥ 2.
- Reset asserted mid-operation: all registers return to reset values at once; `pend_q` is discarded.

## Timing
- Reset values:
  - `state`=IDLE, `cnt`=0, `div_q`=`DEFAULT_DIV`, `pend_q`=0.
  - `tick`=0, `half_tick`=0, `new_clk`=0, `running`=0, `cfg_ready`=1.
- All outputs are registered, except `cfg_ready` and `running`, which are decoded directly from `state`.
- First `tick` is high during the cycle following the `div_q`-th edge after the edge that entered RUN. Subsequent ticks follow every `div_q` cycles.
- `cfg_ready` goes low the cycle after a transfer in RUN. It returns high the cycle after the commit wrap.
- A divisor accepted in RUN affects the period after the current one. The current period always completes with the old divisor.

## Configuration
- `CLK_DIV_CTRL_HALF_TICK_EN` defined: `half_tick` pulses for one cycle when `cnt` becomes `div_q`>>1, coincident with the `new_clk` rising edge, for UART RX mid-bit sampling. It is forced to 0 in IDLE.
- `CLK_DIV_CTRL_HALF_TICK_EN` undefined: `half_tick` is tied to 0 and no related logic is built. The port remains present.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 with `en`=1 and `cfg_valid`=1 toggling.
  - Response: `tick`=0, `new_clk`=0, `running`=0, `cfg_ready`=1.
  - After release, `en`=1 gives `tick` every 5208 cycles.
- Basic run:
  - Stimulus: write `cfg_div`=4 in IDLE, then set `en`=1.
  - Response: `tick` at cycles 4, 8, 12 after entry; `new_clk` pattern 0,0,1,1 repeating; `running`=1.
- Live update:
  - Stimulus: running with div=4; write 6 when `cnt`=1.
  - Response: `cfg_ready`=0 next cycle; the current period ends at 4; following ticks are 6 apart; `cfg_ready`=1 after the commit.
- Clamp:
  - Stimulus: write `cfg_div`=0, then `cfg_div`=1, each followed by a run.
  - Response: `tick` every 2 cycles; `new_clk` alternates 0,1.
- Stop with pending divisor:
  - Stimulus: drop `en` while in PEND (div 4 to 7), including once on the wrap edge.
  - Response: IDLE next cycle; all outputs 0; no tick on the wrap-edge case; re-enabling gives ticks 7 apart.
- Half tick:
  - Stimulus: with `CLK_DIV_CTRL_HALF_TICK_EN` defined, run div=5.
  - Response: `half_tick` when `cnt` becomes 2; `tick` when `cnt` becomes 0; pulses 5 cycles apart, offset by 3.
  - With the macro undefined, `half_tick` stays 0 throughout.
